// File: rtl/jam_cost_table.sv
// Cost matrix store for the job-assignment search: loads 64 row-major 7-bit entries,
// then serves registered lookups. Optional row-minimum lower bound: JAM_COST_TABLE_ROWMIN_EN.
module jam_cost_table (
  input  logic       CLK,
  input  logic       RST,
  input  logic       In_valid,
  input  logic [6:0] In_data,
  output logic       In_ready,
  input  logic       Clear,
  input  logic [2:0] W,
  input  logic [2:0] J,
  output logic [6:0] Cost,
  output logic       Table_ready,
  output logic [9:0] LowerBound
);

  typedef enum logic [0:0] {
    ST_LOAD  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [5:0] idx_r;
  logic [6:0] cost_r;
  logic       accept_s;
  logic       last_s;
  logic [6:0] mem [0:63];

  assign In_ready    = (state_r == ST_LOAD);
  assign Table_ready = (state_r == ST_READY);
  assign accept_s    = In_valid & In_ready & ~Clear;
  assign last_s      = (idx_r == 6'd63);
  assign Cost        = cost_r;

  // Next-state decode; Clear wins over a completing load.
  always_comb begin
    state_s = state_r;
    if (Clear) begin
      state_s = ST_LOAD;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (accept_s && last_s) begin
            state_s = ST_READY;
          end else begin
            state_s = ST_LOAD;
          end
        end
        ST_READY: state_s = ST_READY;
        default:  state_s = ST_LOAD;
      endcase
    end
  end

  // State register and load counter; counter wraps to 0 after entry 63.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_LOAD;
      idx_r   <= 6'd0;
    end else begin
      state_r <= state_s;
      if (Clear) begin
        idx_r <= 6'd0;
      end else if (accept_s) begin
        idx_r <= idx_r + 6'd1;
      end
    end
  end

  // Table storage; deliberately not reset, a fresh load overwrites every entry.
  always_ff @(posedge CLK) begin
    if (accept_s) begin
      mem[idx_r] <= In_data;
    end
  end

  // One-cycle lookup; zero while loading or being cleared.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cost_r <= 7'd0;
    end else if (Clear || (state_r != ST_READY)) begin
      cost_r <= 7'd0;
    end else begin
      cost_r <= mem[{W, J}];
    end
  end

`ifdef JAM_COST_TABLE_ROWMIN_EN
  function automatic logic [6:0] min7(input logic [6:0] a, input logic [6:0] b);
    return (b < a) ? b : a;
  endfunction

  logic [6:0] rowmin_r;
  logic [6:0] min_s;
  logic [9:0] acc_r;
  logic [9:0] acc_s;
  logic [9:0] lb_r;

  // Running minimum including the entry being accepted this cycle.
  always_comb begin
    min_s = In_data;
    if (idx_r[2:0] == 3'd0) begin
      min_s = In_data;
    end else begin
      min_s = min7(rowmin_r, In_data);
    end
    acc_s = acc_r + {3'd0, min_s};
  end

  // Row-min tracking and accumulation; bound published on the final accept.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rowmin_r <= 7'd0;
      acc_r    <= 10'd0;
      lb_r     <= 10'd0;
    end else if (Clear) begin
      rowmin_r <= 7'd0;
      acc_r    <= 10'd0;
      lb_r     <= 10'd0;
    end else if (accept_s) begin
      rowmin_r <= min_s;
      if (idx_r[2:0] == 3'd7) begin
        acc_r <= acc_s;
      end
      lb_r <= last_s ? acc_s : 10'd0;
    end else if (state_r == ST_LOAD) begin
      lb_r <= 10'd0;
    end
  end

  assign LowerBound = lb_r;
`else
  assign LowerBound = 10'd0;
`endif

endmodule

// File: tb/tb_jam_cost_table.sv
// Directed bench for jam_cost_table with a lookup scoreboard queue and a shadow table model.
module tb_jam_cost_table;

  logic       CLK = 1'b0;
  logic       RST;
  logic       In_valid;
  logic [6:0] In_data;
  logic       In_ready;
  logic       Clear;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic       Table_ready;
  logic [9:0] LowerBound;

  jam_cost_table dut (
    .CLK(CLK), .RST(RST), .In_valid(In_valid), .In_data(In_data), .In_ready(In_ready),
    .Clear(Clear), .W(W), .J(J), .Cost(Cost), .Table_ready(Table_ready),
    .LowerBound(LowerBound)
  );

  always #5 CLK = ~CLK;

  int         checks = 0;
  int         errors = 0;
  logic [6:0] exp_mem [0:63];
  logic       m_ready = 1'b0;
  int         m_idx = 0;
  logic [6:0] cost_q [$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [9:0] exp_lb();
    logic [9:0] s;
    logic [6:0] m;
    s = 10'd0;
`ifdef JAM_COST_TABLE_ROWMIN_EN
    if (m_ready) begin
      for (int r = 0; r < 8; r++) begin
        m = exp_mem[r*8];
        for (int c = 1; c < 8; c++) if (exp_mem[r*8+c] < m) m = exp_mem[r*8+c];
        s = s + {3'd0, m};
      end
    end
`endif
    return s;
  endfunction

  task automatic cycle(input logic v, input logic [6:0] d, input logic c,
                       input logic [2:0] w, input logic [2:0] j);
    In_valid = v; In_data = d; Clear = c; W = w; J = j;
    cost_q.push_back((m_ready && !c) ? exp_mem[{w, j}] : 7'd0);
    if (c) begin
      m_ready = 1'b0; m_idx = 0;
    end else if (!m_ready && v) begin
      exp_mem[m_idx] = d;
      if (m_idx == 63) begin m_ready = 1'b1; m_idx = 0; end
      else m_idx++;
    end
    @(posedge CLK); #1;
    chk("cost", {9'd0, Cost}, {9'd0, cost_q.pop_front()});
    chk("table_ready", {15'd0, Table_ready}, {15'd0, m_ready});
    chk("in_ready", {15'd0, In_ready}, {15'd0, !m_ready});
    chk("lower_bound", {6'd0, LowerBound}, {6'd0, exp_lb()});
  endtask

  initial begin
    RST = 1'b1; In_valid = 1'b0; In_data = 7'd0; Clear = 1'b0; W = 3'd0; J = 3'd0;
    #2;
    chk("rst_in_ready", {15'd0, In_ready}, 16'd1);
    chk("rst_table_ready", {15'd0, Table_ready}, 16'd0);
    chk("rst_cost", {9'd0, Cost}, 16'd0);
    chk("rst_lb", {6'd0, LowerBound}, 16'd0);
    @(posedge CLK); #1; RST = 1'b0;

    // continuous load, value (k*5)%128
    for (int k = 0; k < 64; k++) cycle(1'b1, 7'((k * 5) % 128), 1'b0, 3'd0, 3'd0);
    cycle(1'b0, 7'd0, 1'b0, 3'd3, 3'd5);
    chk("lookup_3_5", {9'd0, Cost}, 16'd17);
    cycle(1'b0, 7'd0, 1'b0, 3'd7, 3'd7);
    chk("lookup_7_7", {9'd0, Cost}, 16'd59);

    // pipelined lookups over every pair
    for (int p = 0; p < 64; p++) cycle(1'b0, 7'd0, 1'b0, 3'(p / 8), 3'(p % 8));

    // asynchronous reset mid-cycle while READY with a non-zero Cost
    #3; RST = 1'b1; #1;
    chk("mid_rst_in_ready", {15'd0, In_ready}, 16'd1);
    chk("mid_rst_table_ready", {15'd0, Table_ready}, 16'd0);
    chk("mid_rst_cost", {9'd0, Cost}, 16'd0);
    chk("mid_rst_lb", {6'd0, LowerBound}, 16'd0);
    m_ready = 1'b0; m_idx = 0;
    @(posedge CLK); #1; RST = 1'b0;

    // partial load, then Clear coincident with entry 30
    for (int k = 0; k < 30; k++) cycle(1'b1, 7'd100, 1'b0, 3'd0, 3'd0);
    cycle(1'b1, 7'd100, 1'b1, 3'd0, 3'd0);

    // reload with random valid gaps
    for (int g = 0; g < 2000 && !m_ready; g++)
      cycle(1'($urandom_range(0, 1)), 7'((m_idx * 5) % 128), 1'b0, 3'd2, 3'd1);
    chk("bp_loaded", {15'd0, Table_ready}, 16'd1);
    cycle(1'b1, 7'd99, 1'b0, 3'd0, 3'd0);
    cycle(1'b0, 7'd0, 1'b0, 3'd0, 3'd0);
    chk("no_write_ready", {9'd0, Cost}, 16'd0);
    for (int p = 0; p < 64; p++) cycle(1'b0, 7'd0, 1'b0, 3'(63 - p) / 3'd1 == 3'd0 ? 3'((63 - p) / 8) : 3'((63 - p) / 8), 3'((63 - p) % 8));

    // Clear while READY
    cycle(1'b0, 7'd0, 1'b1, 3'd3, 3'd5);
    chk("clear_ready_cost", {9'd0, Cost}, 16'd0);

    // row-min pattern: minimum of row r is r+1
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        cycle(1'b1, (c == 0) ? 7'(r + 10) : (c == 1) ? 7'd9 : (c == 3) ? 7'(r + 1) : 7'(50 + c),
              1'b0, 3'd0, 3'd0);
`ifdef JAM_COST_TABLE_ROWMIN_EN
    chk("rowmin_lb", {6'd0, LowerBound}, 16'd36);
`else
    chk("rowmin_lb", {6'd0, LowerBound}, 16'd0);
`endif
    cycle(1'b0, 7'd0, 1'b0, 3'd5, 3'd3);
    cycle(1'b0, 7'd0, 1'b0, 3'd6, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
